pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Parametrised successor to the fixed +4 program counter.
- Holds the fetch address and, on each clock edge, advances by a configurable step.
- Supports stall, branch redirect, and call/return through an internal circular return-address stack (RAS).
- Sits at the front of the fetch stage and drives the instruction-memory address.

Parameters:
WIDTH, 32, address width in bits
STEP, 4, sequential increment in bytes; power of two, at least 1
RESET_VECTOR, 0, value loaded into pc on reset; must be a multiple of STEP
RAS_DEPTH, 4, number of return-address entries; power of two, at least 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
stall  input  1  hold pc and RAS unchanged this cycle
branch_en  input  1  redirect pc to target
call_en  input  1  redirect pc to target and push return address
ret_en  input  1  pop RAS into pc
target  input  WIDTH  branch/call destination
pc  output  WIDTH  current fetch address (registered)
ras_empty  output  1  RAS holds zero valid entries
ras_full  output  1  RAS holds RAS_DEPTH valid entries
ras_overflow  output  1  sticky; a push overwrote the oldest entry
ras_underflow  output  1  sticky; ret_en was accepted with the RAS empty
misaligned  output  1  registered; last accepted target had nonzero bits below log2(STEP)

Behaviour:
- Reset (rst_n low, asynchronous): pc=RESET_VECTOR; RAS pointer=0; count=0; ras_empty=1; ras_full=0; ras_overflow=0; ras_underflow=0; misaligned=0. RAS entry contents are don't-care.
- Reset asserted mid-operation: immediately clears all state, including sticky flags. Normal operation resumes on the first rising edge after rst_n goes high.
- All updates occur on the rising edge of clk. A request sampled at edge N is visible on pc after edge N (1-cycle latency). No combinational path from inputs to pc.
- Per-edge priority, highest first:
  - stall: hold everything. All other requests are ignored; misaligned holds.
  - branch_en: pc <= aligned(target). RAS unchanged.
  - call_en: pc <= aligned(target). Push pc+STEP.
  - ret_en: if count>0, pc <= top entry and pop. If count==0, pc <= pc+STEP and set ras_underflow.
  - None asserted: pc <= pc+STEP.
- aligned(x) is x with the low log2(STEP) bits forced to 0.
- misaligned updates on every accepted branch/call with (target & (STEP-1))!=0. Otherwise it is cleared on any accepted non-stall edge.
- Arithmetic: pc+STEP is computed modulo 2^WIDTH. At 2^WIDTH-STEP, pc wraps to 0 with no flag.
- RAS push:
  - Write the entry at ptr, then ptr <= ptr+1 mod RAS_DEPTH.
  - If count==RAS_DEPTH, the oldest entry is overwritten, count stays at RAS_DEPTH, and ras_overflow is set. Otherwise count increments.
  - The pushed value is pc+STEP, modulo 2^WIDTH.
- RAS pop: ptr <= ptr-1 mod RAS_DEPTH; the value read is the entry at ptr-1; count decrements.
- ras_empty = (count==0) and ras_full = (count==RAS_DEPTH), both derived from registered count.
- Simultaneous branch_en, call_en and ret_en: only the highest-priority request takes effect. Lower requests have no side effect; in particular, a ret masked by a branch does not pop.
- Sticky flags clear only on reset.

Test Plan:
- Reset then free-run, defaults, no requests, 5 edges -> pc sequence 0,4,8,12,16,20; ras_empty=1.
- Stall at pc=8 for 3 edges with branch_en=1, target=0x100 -> pc holds 8 for 3 edges; redirect ignored; next free edge gives 12.
- Call at pc=0x10 to target=0x200, run 2 edges, ret -> pc=0x200, 0x204, 0x208, then 0x14; ras_empty returns to 1.
- 5 nested calls (RAS_DEPTH=4) from pc=0,0x100,0x200,0x300,0x400, then 5 rets -> ras_overflow=1 after the 5th call; rets yield 0x404,0x304,0x204,0x104; 5th ret gives pc+4 and sets ras_underflow=1.
- Branch to target=0x203 with STEP=4 -> pc=0x200; misaligned=1; next sequential edge clears misaligned.
- WIDTH=8, STEP=4, pc=0xFC, one edge -> pc=0x00. Assert rst_n low asynchronously mid-cycle -> pc=RESET_VECTOR without waiting for a clk edge; sticky flags cleared.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch program counter with stall, branch, call/return via a circular return-address stack.
// One-cycle latency from request to pc; stall freezes pc, RAS and flags for that edge.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               STEP         = 4,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               RAS_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             branch_en,
    input  logic             call_en,
    input  logic             ret_en,
    input  logic [WIDTH-1:0] target,
    output logic [WIDTH-1:0] pc,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ras_overflow,
    output logic             ras_underflow,
    output logic             misaligned
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] LOW_MASK = WIDTH'(STEP - 1);
    localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_prev;
    logic [CNT_W-1:0] count;

    logic [WIDTH-1:0] pc_seq;
    logic [WIDTH-1:0] target_aligned;
    logic             target_mis;
    logic             do_branch;
    logic             do_call;
    logic             do_ret;
    logic             do_pop;

    // Priority decode: a masked lower-priority request has no side effect at all.
    always_comb begin
        do_branch = !stall && branch_en;
        do_call   = !stall && !branch_en && call_en;
        do_ret    = !stall && !branch_en && !call_en && ret_en;
        do_pop    = do_ret && (count != '0);
    end

    assign pc_seq         = pc + STEP_W;
    assign target_aligned = target & ~LOW_MASK;
    assign target_mis     = |(target & LOW_MASK);
    assign ptr_prev       = ptr - PTR_W'(1);
    assign ras_empty      = (count == '0);
    assign ras_full       = (count == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc            <= RESET_VECTOR;
            ptr           <= '0;
            count         <= '0;
            ras_overflow  <= 1'b0;
            ras_underflow <= 1'b0;
            misaligned    <= 1'b0;
        end else if (!stall) begin
            misaligned <= (do_branch || do_call) && target_mis;

            if (do_branch || do_call) begin
                pc <= target_aligned;
            end else if (do_pop) begin
                pc <= ras_mem[ptr_prev];
            end else begin
                pc <= pc_seq;
            end

            // A push into a full stack recycles the oldest slot; count saturates.
            if (do_call) begin
                ptr <= ptr + PTR_W'(1);
                if (ras_full) begin
                    ras_overflow <= 1'b1;
                end else begin
                    count <= count + CNT_W'(1);
                end
            end else if (do_pop) begin
                ptr   <= ptr_prev;
                count <= count - CNT_W'(1);
            end

            if (do_ret && ras_empty) begin
                ras_underflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_call) begin
            ras_mem[ptr] <= pc_seq;
        end
    end

endmodule
